uart_echo_responder: RTL

Serial-side responder for the 8N1 UART link: receives frames on `i_Rx_Serial`, buffers good bytes in a small FIFO, and retransmits each byte unchanged on `o_Tx_Serial`. It is the far end of the link that the transmit-side logic drives. It acts as a loopback target for link bring-up and for checking the transmit path at the board level. Receive and transmit run concurrently at the same bit rate. A hold input pauses retransmission so that buffering and overflow can be exercised.

---
 rtl/uart_echo_responder.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_echo_responder.sv
// uart_echo_responder: 8N1 UART receiver feeding a small FIFO whose bytes are
// retransmitted unchanged. A hold input pauses retransmission.
// FIFO_DEPTH must be a power of two, at least 2.
module uart_echo_responder #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic                        i_Rx_Serial,
  input  logic                        i_Tx_Hold,
  output logic                        o_Tx_Serial,
  output logic                        o_Tx_Active,
  output logic                        o_Rx_DV,
  output logic [7:0]                  o_Rx_Byte,
  output logic                        o_Frame_Err,
  output logic                        o_Overflow,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // synchronizer and edge detect
  logic sync_meta, rx_s, rx_prev;

  // receiver state
  rx_state_t     rx_state, rx_state_next;
  logic [CW-1:0] rx_cnt, rx_cnt_next;
  logic [2:0]    rx_bit, rx_bit_next;
  logic [7:0]    rx_shift, rx_shift_next;
  logic [7:0]    rx_byte, rx_byte_next;
  logic          rx_dv, rx_dv_next, frame_err, frame_err_next;
  logic          push;

  // fifo state
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_count;
  logic [7:0]    tx_data;
  logic          full, write, pop, overflow, overflow_next;

  // transmitter state
  tx_state_t     tx_state, tx_state_next;
  logic [CW-1:0] tx_cnt, tx_cnt_next;
  logic [2:0]    tx_bit, tx_bit_next;
  logic          tx_serial, tx_serial_next, tx_active, tx_active_next;

  // Two-flop synchronizer plus one extra stage for falling-edge detection
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync_meta <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
    end else begin
      sync_meta <= i_Rx_Serial;
      rx_s      <= sync_meta;
      rx_prev   <= rx_s;
    end
  end

  // RX next-state: the counter starts at 1 on the edge so the start check
  // lands exactly half a bit after the first low synchronized sample
  always_comb begin
    rx_state_next  = rx_state;
    rx_cnt_next    = rx_cnt;
    rx_bit_next    = rx_bit;
    rx_shift_next  = rx_shift;
    rx_byte_next   = rx_byte;
    rx_dv_next     = 1'b0;
    frame_err_next = 1'b0;
    push           = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_state_next = RX_START;
          rx_cnt_next   = CW'(1);
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_CNT) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          rx_state_next = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_next = rx_cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_s, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_next = RX_STOP;
          else                rx_bit_next   = rx_bit + 3'd1;
        end else begin
          rx_cnt_next = rx_cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_next   = '0;
          rx_state_next = RX_IDLE;
          if (rx_s) begin
            rx_byte_next = rx_shift;
            rx_dv_next   = 1'b1;
            push         = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
        end else begin
          rx_cnt_next = rx_cnt + CW'(1);
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_state  <= rx_state_next;
      rx_cnt    <= rx_cnt_next;
      rx_bit    <= rx_bit_next;
      rx_shift  <= rx_shift_next;
      rx_byte   <= rx_byte_next;
      rx_dv     <= rx_dv_next;
      frame_err <= frame_err_next;
    end
  end

  // A push into a full FIFO still succeeds if a pop frees a slot that cycle
  assign full          = (fifo_count == FULL_CNT);
  assign write         = push && (!full || pop);
  assign overflow_next = push && full && !pop;

  // FIFO storage with registered read; reading the old word when the full
  // FIFO is written and read at the same address is the intended behaviour
  always_ff @(posedge i_Clock) begin
    if (write) mem[wr_ptr] <= rx_shift;
    if (pop)   tx_data     <= mem[rd_ptr];
  end

  // FIFO pointers, occupancy and overflow pulse
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({write, pop})
        2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      overflow <= overflow_next;
    end
  end

  // TX next-state: pop in IDLE, then start, 8 data bits LSB first, stop
  always_comb begin
    tx_state_next  = tx_state;
    tx_cnt_next    = tx_cnt;
    tx_bit_next    = tx_bit;
    tx_serial_next = tx_serial;
    tx_active_next = tx_active;
    pop            = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_serial_next = 1'b1;
        tx_active_next = 1'b0;
        if (fifo_count != '0 && !i_Tx_Hold) begin
          pop            = 1'b1;
          tx_state_next  = TX_START;
          tx_cnt_next    = '0;
          tx_serial_next = 1'b0;
          tx_active_next = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_next    = '0;
          tx_bit_next    = '0;
          tx_state_next  = TX_DATA;
          tx_serial_next = tx_data[0];
        end else begin
          tx_cnt_next = tx_cnt + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_next = '0;
          if (tx_bit == 3'd7) begin
            tx_state_next  = TX_STOP;
            tx_serial_next = 1'b1;
          end else begin
            tx_bit_next    = tx_bit + 3'd1;
            tx_serial_next = tx_data[tx_bit_next];
          end
        end else begin
          tx_cnt_next = tx_cnt + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_next    = '0;
          tx_state_next  = TX_IDLE;
          tx_active_next = 1'b0;
        end else begin
          tx_cnt_next = tx_cnt + CW'(1);
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // TX state register
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_serial <= 1'b1;
      tx_active <= 1'b0;
    end else begin
      tx_state  <= tx_state_next;
      tx_cnt    <= tx_cnt_next;
      tx_bit    <= tx_bit_next;
      tx_serial <= tx_serial_next;
      tx_active <= tx_active_next;
    end
  end

  assign o_Tx_Serial  = tx_serial;
  assign o_Tx_Active  = tx_active;
  assign o_Rx_DV      = rx_dv;
  assign o_Rx_Byte    = rx_byte;
  assign o_Frame_Err  = frame_err;
  assign o_Overflow   = overflow;
  assign o_Fifo_Count = fifo_count;
endmodule
